color_reg_port_ctl: RTL

// - CPU-side access controller for the 16-entry color register RAM (18-bit RGB in 24-bit words).
// - Converts 8-bit register-bus writes/reads into whole-word RAM accesses on RAM port A.
// - R, G, B components stream through one data port. Index auto-advances after each complete triple.
// - Pixel pipeline keeps exclusive use of RAM port B. This block never touches it.

---
 rtl/color_reg_port_ctl_if.sv | 44 ++++
 rtl/color_reg_port_ctl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/color_reg_port_ctl_if.sv
// -----------------------------------------------------------------------------
// color_reg_port_ctl_if
// Purpose : bundles the CPU register-bus and RAM port A signals of the color
//           register access controller.
// Signals :
//   cpu_wr_stb, cpu_rd_stb  one-cycle write / read strobes
//   cpu_reg_sel             0 = index register, 1 = data port
//   cpu_din / cpu_dout      8-bit write data / registered read data
//   cpu_busy                high while a prefetch or RAM write is in flight
//   ram_we, ram_addr,       RAM port A write enable, address, write data
//   ram_din
//   ram_dout                RAM port A registered read data
// Modports:
//   master : CPU + RAM side (drives strobes, write data, RAM read data)
//   slave  : the controller
// Handshake: a strobe is a single-cycle pulse and is accepted only when
//   cpu_busy is low; a strobe seen while cpu_busy is high is dropped, so
//   cpu_busy acts as an inverted ready with no back-pressure or retry.
// -----------------------------------------------------------------------------
interface color_reg_port_ctl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 24
);
  logic                  cpu_wr_stb;
  logic                  cpu_rd_stb;
  logic                  cpu_reg_sel;
  logic [7:0]            cpu_din;
  logic [7:0]            cpu_dout;
  logic                  cpu_busy;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (
    output cpu_wr_stb, cpu_rd_stb, cpu_reg_sel, cpu_din, ram_dout,
    input  cpu_dout, cpu_busy, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  cpu_wr_stb, cpu_rd_stb, cpu_reg_sel, cpu_din, ram_dout,
    output cpu_dout, cpu_busy, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/color_reg_port_ctl.sv
// -----------------------------------------------------------------------------
// color_reg_port_ctl
// Purpose : CPU-side access controller for the 16-entry color register RAM.
//           8-bit register-bus accesses are turned into whole-word accesses on
//           RAM port A. R, G and B components stream through one data port via
//           a shadow copy of the current entry; a completed B write commits the
//           shadow word to RAM, and every index change re-prefetches the entry.
// Ports   :
//   clk_dot4x  system clock, rising edge
//   rst_n      asynchronous reset, active low
//   cpu_ram    color_reg_port_ctl_if.slave (CPU bus + RAM port A)
//   state_o    current FSM state (debug)
// Config  : define COLOR_REG_AUTOINC_EN to advance the index (mod 2^ADDR_WIDTH)
//           after every completed B write or B read; otherwise the index holds
//           and the same entry is re-fetched.
// -----------------------------------------------------------------------------
module color_reg_port_ctl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 24,
  parameter int COMP_WIDTH = 6
) (
  input  logic                      clk_dot4x,
  input  logic                      rst_n,
  color_reg_port_ctl_if.slave       cpu_ram,
  output logic [1:0]                state_o
);

  // Width of the always-zero tail below the B lane.
  localparam int PAD_WIDTH = DATA_WIDTH - 3 * COMP_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH0 = 2'd1,
    S_FETCH1 = 2'd2,
    S_WRITE  = 2'd3
  } state_e;

  localparam logic [1:0] COMP_R = 2'd0;
  localparam logic [1:0] COMP_G = 2'd1;
  localparam logic [1:0] COMP_B = 2'd2;

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     index_q;
  logic [1:0]                comp_q;
  logic [3*COMP_WIDTH-1:0]   shadow_q;   // {R, G, B}
  logic [7:0]                dout_q;
  logic                      busy_q;
  logic                      ram_we_q;
  logic [ADDR_WIDTH-1:0]     ram_addr_q;
  logic [DATA_WIDTH-1:0]     ram_din_q;

  logic [COMP_WIDTH-1:0]     cur_lane;
  logic [COMP_WIDTH-1:0]     din_comp;
  logic [ADDR_WIDTH-1:0]     din_index;
  logic [ADDR_WIDTH-1:0]     next_index;
  logic                      unused_bits;

  assign din_comp  = cpu_ram.cpu_din[COMP_WIDTH-1:0];
  assign din_index = cpu_ram.cpu_din[ADDR_WIDTH-1:0];

  // Upper data bits and the RAM pad bits carry no information here.
  assign unused_bits = ^{cpu_ram.cpu_din[7:COMP_WIDTH], cpu_ram.ram_dout[PAD_WIDTH-1:0]};

`ifdef COLOR_REG_AUTOINC_EN
  assign next_index = index_q + 1'b1;
`else
  assign next_index = index_q;
`endif

  // Shadow lane selected by the shared component pointer.
  always_comb begin
    cur_lane = shadow_q[3*COMP_WIDTH-1 -: COMP_WIDTH];
    case (comp_q)
      COMP_G:  cur_lane = shadow_q[2*COMP_WIDTH-1 -: COMP_WIDTH];
      COMP_B:  cur_lane = shadow_q[COMP_WIDTH-1:0];
      default: cur_lane = shadow_q[3*COMP_WIDTH-1 -: COMP_WIDTH];
    endcase
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      comp_q     <= COMP_R;
      shadow_q   <= '0;
      dout_q     <= '0;
      busy_q     <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      ram_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Write has priority; a simultaneous read is dropped.
          if (cpu_ram.cpu_wr_stb) begin
            if (!cpu_ram.cpu_reg_sel) begin
              index_q    <= din_index;
              comp_q     <= COMP_R;
              ram_addr_q <= din_index;
              busy_q     <= 1'b1;
              state_q    <= S_FETCH0;
            end else begin
              case (comp_q)
                COMP_R: begin
                  shadow_q[3*COMP_WIDTH-1 -: COMP_WIDTH] <= din_comp;
                  comp_q <= COMP_G;
                end
                COMP_G: begin
                  shadow_q[2*COMP_WIDTH-1 -: COMP_WIDTH] <= din_comp;
                  comp_q <= COMP_B;
                end
                default: begin
                  // B completes the triple: commit the word at the current
                  // index, then advance the index for the re-prefetch.
                  shadow_q[COMP_WIDTH-1:0] <= din_comp;
                  comp_q     <= COMP_R;
                  ram_we_q   <= 1'b1;
                  ram_addr_q <= index_q;
                  ram_din_q  <= {shadow_q[3*COMP_WIDTH-1:COMP_WIDTH], din_comp,
                                 {PAD_WIDTH{1'b0}}};
                  index_q    <= next_index;
                  busy_q     <= 1'b1;
                  state_q    <= S_WRITE;
                end
              endcase
            end
          end else if (cpu_ram.cpu_rd_stb) begin
            if (!cpu_ram.cpu_reg_sel) begin
              dout_q <= {{(8-ADDR_WIDTH){1'b0}}, index_q};
            end else begin
              dout_q <= {{(8-COMP_WIDTH){1'b0}}, cur_lane};
              if (comp_q == COMP_B) begin
                comp_q     <= COMP_R;
                index_q    <= next_index;
                ram_addr_q <= next_index;
                busy_q     <= 1'b1;
                state_q    <= S_FETCH0;
              end else begin
                comp_q <= comp_q + 2'd1;
              end
            end
          end
        end
        // RAM samples ram_addr at the end of this cycle.
        S_FETCH0: state_q <= S_FETCH1;
        S_FETCH1: begin
          shadow_q <= cpu_ram.ram_dout[DATA_WIDTH-1:PAD_WIDTH];
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        // index_q already holds the next entry to prefetch.
        S_WRITE: begin
          ram_addr_q <= index_q;
          state_q    <= S_FETCH0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_ram.cpu_dout = dout_q;
  assign cpu_ram.cpu_busy = busy_q;
  assign cpu_ram.ram_we   = ram_we_q;
  assign cpu_ram.ram_addr = ram_addr_q;
  assign cpu_ram.ram_din  = ram_din_q;
  assign state_o          = state_q;

endmodule
